// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - traffic light phase sequencer with per-second countdown
// Lamps and countdown digit are registered; a sticky pedestrian request shortens green.
module traffic_light_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int RED_TIME    = 9,
  parameter int RY_TIME     = 3,
  parameter int GREEN_TIME  = 9,
  parameter int YELLOW_TIME = 3,
  parameter int PED_MIN     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [7:0] count,
  output logic       count_we
);

  localparam int            PW       = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PS_MAX   = PW'(CLK_PER_SEC - 1);
  localparam logic [3:0]    T_RED    = 4'(RED_TIME);
  localparam logic [3:0]    T_RY     = 4'(RY_TIME);
  localparam logic [3:0]    T_GREEN  = 4'(GREEN_TIME);
  localparam logic [3:0]    T_YELLOW = 4'(YELLOW_TIME);
  localparam logic [3:0]    T_PED    = 4'(PED_MIN);

  typedef enum logic [1:0] {
    S_RED,
    S_RED_YELLOW,
    S_GREEN,
    S_YELLOW
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [3:0]    cnt;
  logic          ped_pend;
  logic          tick;
  logic          last_sec;

  assign tick     = en && (prescaler == PS_MAX);
  assign last_sec = (cnt == 4'd1);
  assign count    = {4'b0000, cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RED;
      red       <= 1'b1;
      yellow    <= 1'b0;
      green     <= 1'b0;
      cnt       <= T_RED;
      count_we  <= 1'b0;
      prescaler <= '0;
      ped_pend  <= 1'b0;
    end else begin
      count_we <= en;

      if (en) begin
        prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + 1'b1;
      end

      // A new request on the RED-entry edge wins over the clear.
      if (ped_req) begin
        ped_pend <= 1'b1;
      end else if (tick && last_sec && state == S_YELLOW) begin
        ped_pend <= 1'b0;
      end

      if (tick) begin
        if (last_sec) begin
          unique case (state)
            S_RED: begin
              state  <= S_RED_YELLOW;
              cnt    <= T_RY;
              red    <= 1'b1;
              yellow <= 1'b1;
              green  <= 1'b0;
            end
            S_RED_YELLOW: begin
              state  <= S_GREEN;
              cnt    <= T_GREEN;
              red    <= 1'b0;
              yellow <= 1'b0;
              green  <= 1'b1;
            end
            S_GREEN: begin
              state  <= S_YELLOW;
              cnt    <= T_YELLOW;
              red    <= 1'b0;
              yellow <= 1'b1;
              green  <= 1'b0;
            end
            S_YELLOW: begin
              state  <= S_RED;
              cnt    <= T_RED;
              red    <= 1'b1;
              yellow <= 1'b0;
              green  <= 1'b0;
            end
          endcase
        end else if (state == S_GREEN && ped_pend && cnt > T_PED) begin
          cnt <= T_PED;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl
// Phase-table model checked every cycle, plus hand-computed literal checkpoints.
module tb_traffic_light_ctrl;

  localparam int CPS     = 4;
  localparam int PED_MIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       ped_req = 1'b0;
  logic       red, yellow, green;
  logic [7:0] count;
  logic       count_we;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;
  bit chk_on   = 1'b0;

  traffic_light_ctrl #(
    .CLK_PER_SEC(CPS),
    .RED_TIME(9),
    .RY_TIME(3),
    .GREEN_TIME(9),
    .YELLOW_TIME(3),
    .PED_MIN(PED_MIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .ped_req(ped_req),
    .red(red),
    .yellow(yellow),
    .green(green),
    .count(count),
    .count_we(count_we)
  );

  always #5 clk = ~clk;

  // Phase table: duration and {red,yellow,green} for RED, RED_YELLOW, GREEN, YELLOW.
  int         dur  [4] = '{9, 3, 9, 3};
  logic [2:0] lamp [4] = '{3'b100, 3'b110, 3'b001, 3'b010};

  int m_phase, m_left, m_sub;
  bit m_pend, m_we, enter_red;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = dur[0];
      m_sub   = 0;
      m_pend  = 1'b0;
      m_we    = 1'b0;
    end else begin
      enter_red = 1'b0;
      m_we = en;
      if (en) begin
        m_sub = m_sub + 1;
        if (m_sub == CPS) begin
          m_sub = 0;
          if (m_left == 1) begin
            m_phase   = (m_phase + 1) % 4;
            m_left    = dur[m_phase];
            enter_red = (m_phase == 0);
          end else if (m_phase == 2 && m_pend && m_left > PED_MIN) begin
            m_left = PED_MIN;
          end else begin
            m_left = m_left - 1;
          end
        end
      end
      if (ped_req) m_pend = 1'b1;
      else if (enter_red) m_pend = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cur, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("model_lamps", {red, yellow, green}, lamp[m_phase]);
      chk("model_count", count, m_left);
      chk("model_count_we", count_we, m_we);
      chk("model_ped_pend", dut.ped_pend, m_pend);
    end
  end

  task automatic goto(input int t);
    while (cur < t) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic lit(input string name, input int lamps, input int cnt_exp);
    chk({name, "_lamps"}, {red, yellow, green}, lamps);
    chk({name, "_count"}, count, cnt_exp);
  endtask

  initial begin
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    lit("rst_async", 3'b100, 9);
    chk("rst_async_we", count_we, 0);
    chk("rst_async_pend", dut.ped_pend, 0);
    @(negedge clk);
    rst = 1'b0;
    cur = 0;
    chk_on = 1'b1;

    goto(1);   chk("we_first_edge", count_we, 1); lit("first_edge", 3'b100, 9);
    goto(4);   lit("first_tick", 3'b100, 8);
    goto(36);  lit("enter_ry", 3'b110, 3);
    goto(48);  lit("enter_green", 3'b001, 9);
    goto(56);  lit("green7", 3'b001, 7);

    goto(57);  ped_req = 1'b1;
    goto(58);  ped_req = 1'b0;
    goto(60);  lit("ped_cut", 3'b001, 3);
    goto(64);  lit("ped_cut2", 3'b001, 2);
    goto(68);  lit("ped_cut1", 3'b001, 1);
    goto(72);  lit("yellow_after_cut", 3'b010, 3);
    goto(84);  lit("red_after_cut", 3'b100, 9); chk("pend_clr", dut.ped_pend, 0);

    goto(160); lit("green2", 3'b001, 2);
    ped_req = 1'b1;
    goto(161); ped_req = 1'b0;
    goto(164); lit("late_ped1", 3'b001, 1);
    goto(168); lit("late_ped_yellow", 3'b010, 3);
    goto(180); lit("late_ped_red", 3'b100, 9); chk("late_pend_clr", dut.ped_pend, 0);

    goto(244); lit("green5", 3'b001, 5);
    goto(246); en = 1'b0;
    goto(250); lit("frozen", 3'b001, 5); chk("frozen_we", count_we, 0);
    chk("frozen_ps", dut.prescaler, 2);
    goto(256); en = 1'b1;
    goto(257); lit("resume", 3'b001, 5); chk("resume_we", count_we, 1);
    goto(258); lit("resume_tick", 3'b001, 4);

    goto(324); ped_req = 1'b1;
    goto(325); ped_req = 1'b0;
    goto(334); lit("ry_ped_green", 3'b001, 9); chk("ry_ped_pend", dut.ped_pend, 1);
    goto(338); lit("ry_ped_cut", 3'b001, 3);
    goto(350); lit("ry_ped_yellow", 3'b010, 3);

    goto(351); ped_req = 1'b1;
    goto(352); ped_req = 1'b0;
    goto(353);
    #2 rst = 1'b1;
    #1;
    lit("rst_mid", 3'b100, 9);
    chk("rst_mid_pend", dut.ped_pend, 0);
    chk("rst_mid_we", count_we, 0);
    @(negedge clk);
    rst = 1'b0;
    cur = 0;

    goto(48);  lit("post_rst_green", 3'b001, 9);
    goto(72);  lit("post_rst_full3", 3'b001, 3);
    goto(80);  lit("post_rst_full1", 3'b001, 1);
    goto(84);  lit("post_rst_yellow", 3'b010, 3);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
